// File: rtl/rs_age_ordered_station.sv
// rs_age_ordered_station
// Reservation station between ROB dispatch and a single functional unit.
// Holds up to RS_SIZE ops, captures operands and NZCV flags from CDB_PORTS
// broadcast buses, and issues the oldest fully-ready entry through a
// valid/ready handshake. A mispredict flush empties the station.
//
// Optional feature macro: RS_PERF_CNT_EN adds saturating counters
// out_full_cycles and out_issue_count.
//
// Ports
//   in_clk, in_rst_n        clock (posedge), asynchronous active-low reset
//   in_disp_* / out_disp_ready   dispatch request and free-entry indication
//   in_cdb_*                 broadcast buses, one lane per port, port 0 in LSBs
//   in_flush                 invalidates every entry at the next edge
//   out_issue_* / in_issue_ready issued entry (combinational from state)
//   out_count                number of occupied entries
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and the payload is stable while
// valid is high and ready is low (unless an older entry becomes ready).
module rs_age_ordered_station #(
  parameter int RS_SIZE      = 8,
  parameter int RS_IDX_SIZE  = 3,
  parameter int CDB_PORTS    = 2,
  parameter int GPR_SIZE     = 64,
  parameter int ROB_IDX_SIZE = 4,
  parameter int OP_W         = 5
) (
  input  logic                              in_clk,
  input  logic                              in_rst_n,
  input  logic                              in_disp_valid,
  output logic                              out_disp_ready,
  input  logic [OP_W-1:0]                   in_disp_op,
  input  logic [ROB_IDX_SIZE-1:0]           in_disp_dst,
  input  logic                              in_disp_a_valid,
  input  logic [GPR_SIZE-1:0]               in_disp_a_value,
  input  logic [ROB_IDX_SIZE-1:0]           in_disp_a_tag,
  input  logic                              in_disp_b_valid,
  input  logic [GPR_SIZE-1:0]               in_disp_b_value,
  input  logic [ROB_IDX_SIZE-1:0]           in_disp_b_tag,
  input  logic                              in_disp_uses_nzcv,
  input  logic                              in_disp_set_nzcv,
  input  logic                              in_disp_nzcv_valid,
  input  logic [3:0]                        in_disp_nzcv_value,
  input  logic [ROB_IDX_SIZE-1:0]           in_disp_nzcv_tag,
  input  logic [CDB_PORTS-1:0]              in_cdb_valid,
  input  logic [CDB_PORTS*ROB_IDX_SIZE-1:0] in_cdb_tag,
  input  logic [CDB_PORTS*GPR_SIZE-1:0]     in_cdb_value,
  input  logic [CDB_PORTS-1:0]              in_cdb_set_nzcv,
  input  logic [CDB_PORTS*4-1:0]            in_cdb_nzcv,
  input  logic                              in_flush,
  output logic                              out_issue_valid,
  input  logic                              in_issue_ready,
  output logic [OP_W-1:0]                   out_issue_op,
  output logic [ROB_IDX_SIZE-1:0]           out_issue_dst,
  output logic [GPR_SIZE-1:0]               out_issue_val_a,
  output logic [GPR_SIZE-1:0]               out_issue_val_b,
  output logic [3:0]                        out_issue_nzcv,
  output logic                              out_issue_set_nzcv,
  output logic [RS_IDX_SIZE:0]              out_count
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0]                       out_full_cycles,
  output logic [31:0]                       out_issue_count
`endif
);
  localparam int CW = RS_IDX_SIZE + 1;
  localparam int TW = ROB_IDX_SIZE;

  logic [RS_SIZE-1:0]  valid_q, valid_d, a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [RS_SIZE-1:0]  f_valid_q, f_valid_d, uses_q, uses_d, set_q, set_d;
  logic [OP_W-1:0]     op_q    [RS_SIZE];
  logic [OP_W-1:0]     op_d    [RS_SIZE];
  logic [TW-1:0]       dst_q   [RS_SIZE];
  logic [TW-1:0]       dst_d   [RS_SIZE];
  logic [GPR_SIZE-1:0] a_val_q [RS_SIZE];
  logic [GPR_SIZE-1:0] a_val_d [RS_SIZE];
  logic [GPR_SIZE-1:0] b_val_q [RS_SIZE];
  logic [GPR_SIZE-1:0] b_val_d [RS_SIZE];
  logic [TW-1:0]       a_tag_q [RS_SIZE];
  logic [TW-1:0]       a_tag_d [RS_SIZE];
  logic [TW-1:0]       b_tag_q [RS_SIZE];
  logic [TW-1:0]       b_tag_d [RS_SIZE];
  logic [TW-1:0]       f_tag_q [RS_SIZE];
  logic [TW-1:0]       f_tag_d [RS_SIZE];
  logic [3:0]          f_val_q [RS_SIZE];
  logic [3:0]          f_val_d [RS_SIZE];
  // older_q[i][j] = 1: entry i was allocated before entry j
  logic [RS_SIZE-1:0]  older_q [RS_SIZE];
  logic [RS_SIZE-1:0]  older_d [RS_SIZE];
  logic [CW-1:0]       count_q, count_d;

  logic [RS_SIZE-1:0]     rdy, grant;
  logic [RS_IDX_SIZE-1:0] alloc_idx;
  logic                   disp_fire, issue_fire;
  logic                   byp_a_v, byp_b_v, byp_f_v;
  logic [GPR_SIZE-1:0]    byp_a_x, byp_b_x;
  logic [3:0]             byp_f_x;

  // Ready vector and age-matrix select: an entry wins when no other ready
  // entry is older than it. Among valid entries the matrix is a total order,
  // so grant is one-hot or zero.
  always_comb begin
    rdy   = valid_q & a_valid_q & b_valid_q & (~uses_q | f_valid_q);
    grant = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < RS_SIZE; j++)
        if (rdy[j] && older_q[j][i]) blocked = 1'b1;
      grant[i] = rdy[i] & ~blocked;
    end
  end

  always_comb begin
    out_issue_valid    = |rdy;
    out_issue_op       = '0;
    out_issue_dst      = '0;
    out_issue_val_a    = '0;
    out_issue_val_b    = '0;
    out_issue_nzcv     = '0;
    out_issue_set_nzcv = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (grant[i]) begin
        out_issue_op       = op_q[i];
        out_issue_dst      = dst_q[i];
        out_issue_val_a    = a_val_q[i];
        out_issue_val_b    = b_val_q[i];
        out_issue_nzcv     = f_val_q[i];
        out_issue_set_nzcv = set_q[i];
      end
    end
  end

  // Lowest free slot from registered state: a slot freed by this cycle's
  // issue is not visible here until the next cycle.
  always_comb begin
    alloc_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (!valid_q[i]) alloc_idx = RS_IDX_SIZE'(i);
  end

  assign out_disp_ready = (count_q != CW'(RS_SIZE));
  assign out_count      = count_q;
  assign disp_fire      = in_disp_valid & out_disp_ready & ~in_flush;
  assign issue_fire     = out_issue_valid & in_issue_ready & ~in_flush;

  // Same-cycle bypass for the dispatching op. Ports are scanned high to low
  // so the lowest matching port is the last assignment and wins.
  always_comb begin
    byp_a_v = in_disp_a_valid;
    byp_a_x = in_disp_a_value;
    byp_b_v = in_disp_b_valid;
    byp_b_x = in_disp_b_value;
    byp_f_v = in_disp_nzcv_valid;
    byp_f_x = in_disp_nzcv_value;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (!in_disp_a_valid && in_cdb_valid[p] && in_cdb_tag[p*TW +: TW] == in_disp_a_tag) begin
        byp_a_v = 1'b1;
        byp_a_x = in_cdb_value[p*GPR_SIZE +: GPR_SIZE];
      end
      if (!in_disp_b_valid && in_cdb_valid[p] && in_cdb_tag[p*TW +: TW] == in_disp_b_tag) begin
        byp_b_v = 1'b1;
        byp_b_x = in_cdb_value[p*GPR_SIZE +: GPR_SIZE];
      end
      if (in_disp_uses_nzcv && !in_disp_nzcv_valid && in_cdb_valid[p] && in_cdb_set_nzcv[p] &&
          in_cdb_tag[p*TW +: TW] == in_disp_nzcv_tag) begin
        byp_f_v = 1'b1;
        byp_f_x = in_cdb_nzcv[p*4 +: 4];
      end
    end
  end

  always_comb begin
    valid_d = valid_q; a_valid_d = a_valid_q; b_valid_d = b_valid_q;
    f_valid_d = f_valid_q; uses_d = uses_q; set_d = set_q;
    op_d = op_q; dst_d = dst_q; a_val_d = a_val_q; b_val_d = b_val_q;
    a_tag_d = a_tag_q; b_tag_d = b_tag_q; f_tag_d = f_tag_q; f_val_d = f_val_q;
    older_d = older_q;
    count_d = count_q;

    // Wakeup of resident entries; lowest matching port wins.
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (valid_q[i] && !a_valid_q[i] && in_cdb_valid[p] && in_cdb_tag[p*TW +: TW] == a_tag_q[i]) begin
          a_valid_d[i] = 1'b1;
          a_val_d[i]   = in_cdb_value[p*GPR_SIZE +: GPR_SIZE];
        end
        if (valid_q[i] && !b_valid_q[i] && in_cdb_valid[p] && in_cdb_tag[p*TW +: TW] == b_tag_q[i]) begin
          b_valid_d[i] = 1'b1;
          b_val_d[i]   = in_cdb_value[p*GPR_SIZE +: GPR_SIZE];
        end
        if (valid_q[i] && uses_q[i] && !f_valid_q[i] && in_cdb_valid[p] && in_cdb_set_nzcv[p] &&
            in_cdb_tag[p*TW +: TW] == f_tag_q[i]) begin
          f_valid_d[i] = 1'b1;
          f_val_d[i]   = in_cdb_nzcv[p*4 +: 4];
        end
      end
    end

    if (issue_fire) valid_d = valid_q & ~grant;

    if (disp_fire) begin
      valid_d[alloc_idx]   = 1'b1;
      op_d[alloc_idx]      = in_disp_op;
      dst_d[alloc_idx]     = in_disp_dst;
      a_valid_d[alloc_idx] = byp_a_v;
      a_val_d[alloc_idx]   = byp_a_x;
      a_tag_d[alloc_idx]   = in_disp_a_tag;
      b_valid_d[alloc_idx] = byp_b_v;
      b_val_d[alloc_idx]   = byp_b_x;
      b_tag_d[alloc_idx]   = in_disp_b_tag;
      uses_d[alloc_idx]    = in_disp_uses_nzcv;
      set_d[alloc_idx]     = in_disp_set_nzcv;
      f_valid_d[alloc_idx] = byp_f_v;
      f_val_d[alloc_idx]   = byp_f_x;
      f_tag_d[alloc_idx]   = in_disp_nzcv_tag;
      // New entry is younger than everything currently resident.
      older_d[alloc_idx]   = '0;
      for (int j = 0; j < RS_SIZE; j++)
        if (valid_q[j]) older_d[j][alloc_idx] = 1'b1;
    end

    count_d = count_q + CW'(disp_fire) - CW'(issue_fire);

    if (in_flush) begin
      valid_d = '0;
      for (int i = 0; i < RS_SIZE; i++) older_d[i] = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      valid_q <= '0; a_valid_q <= '0; b_valid_q <= '0;
      f_valid_q <= '0; uses_q <= '0; set_q <= '0;
      count_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i] <= '0; dst_q[i] <= '0; a_val_q[i] <= '0; b_val_q[i] <= '0;
        a_tag_q[i] <= '0; b_tag_q[i] <= '0; f_tag_q[i] <= '0; f_val_q[i] <= '0;
        older_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d; a_valid_q <= a_valid_d; b_valid_q <= b_valid_d;
      f_valid_q <= f_valid_d; uses_q <= uses_d; set_q <= set_d;
      count_q <= count_d;
      op_q <= op_d; dst_q <= dst_d; a_val_q <= a_val_d; b_val_q <= b_val_d;
      a_tag_q <= a_tag_d; b_tag_q <= b_tag_d; f_tag_q <= f_tag_d; f_val_q <= f_val_d;
      older_q <= older_d;
    end
  end

`ifdef RS_PERF_CNT_EN
  logic [31:0] full_cycles_q, full_cycles_d, issue_count_q, issue_count_d;

  always_comb begin
    full_cycles_d = full_cycles_q;
    issue_count_d = issue_count_q;
    if (!out_disp_ready && full_cycles_q != 32'hFFFF_FFFF) full_cycles_d = full_cycles_q + 32'd1;
    if (issue_fire && issue_count_q != 32'hFFFF_FFFF)      issue_count_d = issue_count_q + 32'd1;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      full_cycles_q <= '0;
      issue_count_q <= '0;
    end else begin
      full_cycles_q <= full_cycles_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign out_full_cycles = full_cycles_q;
  assign out_issue_count = issue_count_q;
`endif
endmodule

// File: tb/tb_rs_age_ordered_station.sv
// Bench for rs_age_ordered_station: directed vectors, an expected-issue
// queue filled at dispatch time, and a monitor that pops and compares on
// every accepted issue handshake.
module tb_rs_age_ordered_station;
  localparam int W = 5 + 4 + 64 + 64 + 4 + 1;

  logic         in_clk = 1'b0, in_rst_n = 1'b0;
  logic         in_disp_valid = 1'b0, out_disp_ready;
  logic [4:0]   in_disp_op = '0;
  logic [3:0]   in_disp_dst = '0;
  logic         in_disp_a_valid = 1'b0, in_disp_b_valid = 1'b0;
  logic [63:0]  in_disp_a_value = '0, in_disp_b_value = '0;
  logic [3:0]   in_disp_a_tag = '0, in_disp_b_tag = '0;
  logic         in_disp_uses_nzcv = 1'b0, in_disp_set_nzcv = 1'b0, in_disp_nzcv_valid = 1'b0;
  logic [3:0]   in_disp_nzcv_value = '0, in_disp_nzcv_tag = '0;
  logic [1:0]   in_cdb_valid = '0, in_cdb_set_nzcv = '0;
  logic [7:0]   in_cdb_tag = '0, in_cdb_nzcv = '0;
  logic [127:0] in_cdb_value = '0;
  logic         in_flush = 1'b0, in_issue_ready = 1'b0;
  logic         out_issue_valid, out_issue_set_nzcv;
  logic [4:0]   out_issue_op;
  logic [3:0]   out_issue_dst, out_issue_nzcv;
  logic [63:0]  out_issue_val_a, out_issue_val_b;
  logic [3:0]   out_count;
`ifdef RS_PERF_CNT_EN
  logic [31:0]  out_full_cycles, out_issue_count;
`endif

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  rs_age_ordered_station dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n),
    .in_disp_valid(in_disp_valid), .out_disp_ready(out_disp_ready),
    .in_disp_op(in_disp_op), .in_disp_dst(in_disp_dst),
    .in_disp_a_valid(in_disp_a_valid), .in_disp_a_value(in_disp_a_value), .in_disp_a_tag(in_disp_a_tag),
    .in_disp_b_valid(in_disp_b_valid), .in_disp_b_value(in_disp_b_value), .in_disp_b_tag(in_disp_b_tag),
    .in_disp_uses_nzcv(in_disp_uses_nzcv), .in_disp_set_nzcv(in_disp_set_nzcv),
    .in_disp_nzcv_valid(in_disp_nzcv_valid), .in_disp_nzcv_value(in_disp_nzcv_value),
    .in_disp_nzcv_tag(in_disp_nzcv_tag),
    .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .in_cdb_set_nzcv(in_cdb_set_nzcv), .in_cdb_nzcv(in_cdb_nzcv),
    .in_flush(in_flush),
    .out_issue_valid(out_issue_valid), .in_issue_ready(in_issue_ready),
    .out_issue_op(out_issue_op), .out_issue_dst(out_issue_dst),
    .out_issue_val_a(out_issue_val_a), .out_issue_val_b(out_issue_val_b),
    .out_issue_nzcv(out_issue_nzcv), .out_issue_set_nzcv(out_issue_set_nzcv),
    .out_count(out_count)
`ifdef RS_PERF_CNT_EN
    , .out_full_cycles(out_full_cycles), .out_issue_count(out_issue_count)
`endif
  );

  // Clock / reset
  always #5 in_clk = ~in_clk;

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_exp(input logic [4:0] op, input logic [3:0] dst,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] nzcv, input logic setf);
    return {op, dst, a, b, nzcv, setf};
  endfunction

  // Driver tasks
  task automatic set_disp(input logic [4:0] op, input logic [3:0] dst,
                          input logic av, input logic [63:0] ax, input logic [3:0] at,
                          input logic bv, input logic [63:0] bx, input logic [3:0] bt);
    in_disp_valid = 1'b1; in_disp_op = op; in_disp_dst = dst;
    in_disp_a_valid = av; in_disp_a_value = ax; in_disp_a_tag = at;
    in_disp_b_valid = bv; in_disp_b_value = bx; in_disp_b_tag = bt;
    in_disp_uses_nzcv = 1'b0; in_disp_set_nzcv = 1'b0; in_disp_nzcv_valid = 1'b0;
    in_disp_nzcv_value = '0; in_disp_nzcv_tag = '0;
  endtask

  task automatic clr_disp();
    in_disp_valid = 1'b0;
  endtask

  task automatic set_cdb(input int p, input logic [3:0] tag, input logic [63:0] val,
                         input logic setf, input logic [3:0] nzcv);
    in_cdb_valid[p] = 1'b1;
    in_cdb_tag[p*4 +: 4] = tag;
    in_cdb_value[p*64 +: 64] = val;
    in_cdb_set_nzcv[p] = setf;
    in_cdb_nzcv[p*4 +: 4] = nzcv;
  endtask

  task automatic clr_cdb();
    in_cdb_valid = '0; in_cdb_set_nzcv = '0;
  endtask

  // Scoreboard monitor: compares on every accepted issue.
  always @(negedge in_clk) begin
    if (in_rst_n && out_issue_valid && in_issue_ready && !in_flush) begin
      logic [W-1:0] act;
      act = {out_issue_op, out_issue_dst, out_issue_val_a, out_issue_val_b, out_issue_nzcv, out_issue_set_nzcv};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL issue_unexpected: got %0h expected none", act);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL issue_payload: got %0h expected %0h", act, e);
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_disp_ready", 64'(out_disp_ready), 64'd1);
    check("rst_issue_valid", 64'(out_issue_valid), 64'd0);
    check("rst_val_a", out_issue_val_a, 64'd0);
    tick();
    in_rst_n = 1'b1;
    tick();

    // Simple ADD, both sources present: issues next cycle
    set_disp(5'd1, 4'd1, 1'b1, 64'd5, 4'd0, 1'b1, 64'd7, 4'd0);
    exp_q.push_back(pack_exp(5'd1, 4'd1, 64'd5, 64'd7, 4'd0, 1'b0));
    tick();
    clr_disp();
    check("add_issue_valid", 64'(out_issue_valid), 64'd1);
    check("add_val_a", out_issue_val_a, 64'd5);
    check("add_count", 64'(out_count), 64'd1);
    in_issue_ready = 1'b1;
    tick();
    in_issue_ready = 1'b0;
    check("add_count_after", 64'(out_count), 64'd0);
    check("add_issue_valid_after", 64'(out_issue_valid), 64'd0);

    // Wakeup: A pending on tag 3, broadcast on port 1 two cycles later
    set_disp(5'd2, 4'd2, 1'b0, 64'd0, 4'd3, 1'b1, 64'd11, 4'd0);
    exp_q.push_back(pack_exp(5'd2, 4'd2, 64'd42, 64'd11, 4'd0, 1'b0));
    tick();
    clr_disp();
    check("wake_wait0", 64'(out_issue_valid), 64'd0);
    tick();
    check("wake_wait1", 64'(out_issue_valid), 64'd0);
    set_cdb(1, 4'd3, 64'd42, 1'b0, 4'd0);
    #3;
    check("wake_not_same_cycle", 64'(out_issue_valid), 64'd0);
    tick();
    clr_cdb();
    check("wake_issue_valid", 64'(out_issue_valid), 64'd1);
    in_issue_ready = 1'b1;
    tick();
    in_issue_ready = 1'b0;

    // Same-cycle bypass, both ports match: port 0 value wins
    set_disp(5'd3, 4'd3, 1'b0, 64'd0, 4'd6, 1'b1, 64'd1, 4'd0);
    set_cdb(0, 4'd6, 64'd9, 1'b0, 4'd0);
    set_cdb(1, 4'd6, 64'd99, 1'b0, 4'd0);
    exp_q.push_back(pack_exp(5'd3, 4'd3, 64'd9, 64'd1, 4'd0, 1'b0));
    tick();
    clr_disp();
    clr_cdb();
    check("bypass_issue_valid", 64'(out_issue_valid), 64'd1);
    in_issue_ready = 1'b1;
    tick();
    in_issue_ready = 1'b0;

    // Fill to RS_SIZE with ready=0, then drain in dispatch order
    for (int i = 0; i < 8; i++) begin
      set_disp(5'd4, 4'(i), 1'b1, 64'(100 + i), 4'd0, 1'b1, 64'(200 + i), 4'd0);
      exp_q.push_back(pack_exp(5'd4, 4'(i), 64'(100 + i), 64'(200 + i), 4'd0, 1'b0));
      tick();
    end
    clr_disp();
    check("full_count", 64'(out_count), 64'd8);
    check("full_disp_ready", 64'(out_disp_ready), 64'd0);
    check("full_oldest_dst", 64'(out_issue_dst), 64'd0);
    // Full plus simultaneous issue: this dispatch must be rejected
    set_disp(5'd9, 4'd15, 1'b1, 64'd1, 4'd0, 1'b1, 64'd1, 4'd0);
    in_issue_ready = 1'b1;
    tick();
    clr_disp();
    check("full_reject_count", 64'(out_count), 64'd7);
    for (int i = 0; i < 7; i++) tick();
    in_issue_ready = 1'b0;
    check("drain_count", 64'(out_count), 64'd0);
    check("drain_issue_valid", 64'(out_issue_valid), 64'd0);

    // Age: younger ready entry held, then older becomes ready and overtakes
    set_disp(5'd5, 4'd10, 1'b0, 64'd0, 4'd4, 1'b1, 64'd2, 4'd0);
    exp_q.push_back(pack_exp(5'd5, 4'd10, 64'd77, 64'd2, 4'd0, 1'b0));
    tick();
    set_disp(5'd6, 4'd11, 1'b1, 64'd3, 4'd0, 1'b1, 64'd4, 4'd0);
    exp_q.push_back(pack_exp(5'd6, 4'd11, 64'd3, 64'd4, 4'd0, 1'b0));
    tick();
    clr_disp();
    check("age_young_dst", 64'(out_issue_dst), 64'd11);
    tick();
    check("age_hold_dst", 64'(out_issue_dst), 64'd11);
    set_cdb(0, 4'd4, 64'd77, 1'b0, 4'd0);
    tick();
    clr_cdb();
    check("age_old_dst", 64'(out_issue_dst), 64'd10);
    in_issue_ready = 1'b1;
    tick();
    tick();
    in_issue_ready = 1'b0;
    check("age_count", 64'(out_count), 64'd0);

    // Flush with 4 pending entries and a simultaneous dispatch
    for (int i = 0; i < 4; i++) begin
      set_disp(5'd7, 4'(i), 1'b0, 64'd0, 4'd9, 1'b1, 64'd0, 4'd0);
      tick();
    end
    check("pre_flush_count", 64'(out_count), 64'd4);
    set_disp(5'd8, 4'd12, 1'b1, 64'd1, 4'd0, 1'b1, 64'd1, 4'd0);
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    clr_disp();
    check("flush_count", 64'(out_count), 64'd0);
    check("flush_disp_ready", 64'(out_disp_ready), 64'd1);
    set_cdb(0, 4'd9, 64'd5, 1'b0, 4'd0);
    tick();
    clr_cdb();
    check("flush_no_issue", 64'(out_issue_valid), 64'd0);

    // Flag wakeup needs set_nzcv on the broadcast
    set_disp(5'd10, 4'd5, 1'b1, 64'd8, 4'd0, 1'b1, 64'd9, 4'd0);
    in_disp_uses_nzcv = 1'b1; in_disp_set_nzcv = 1'b1; in_disp_nzcv_tag = 4'd2;
    exp_q.push_back(pack_exp(5'd10, 4'd5, 64'd8, 64'd9, 4'b0100, 1'b1));
    tick();
    clr_disp();
    check("nzcv_wait", 64'(out_issue_valid), 64'd0);
    set_cdb(0, 4'd2, 64'd0, 1'b0, 4'b1111);
    tick();
    clr_cdb();
    check("nzcv_no_set", 64'(out_issue_valid), 64'd0);
    set_cdb(1, 4'd2, 64'd0, 1'b1, 4'b0100);
    tick();
    clr_cdb();
    check("nzcv_issue_valid", 64'(out_issue_valid), 64'd1);
    check("nzcv_value", 64'(out_issue_nzcv), 64'b0100);
    in_issue_ready = 1'b1;
    tick();
    in_issue_ready = 1'b0;

    // Asynchronous reset mid-operation drops entries immediately
    set_disp(5'd11, 4'd6, 1'b1, 64'd1, 4'd0, 1'b1, 64'd1, 4'd0);
    tick();
    tick();
    clr_disp();
    check("pre_rst_count", 64'(out_count), 64'd2);
    #2;
    in_rst_n = 1'b0;
    #1;
    check("mid_rst_count", 64'(out_count), 64'd0);
    check("mid_rst_issue_valid", 64'(out_issue_valid), 64'd0);
    tick();
    in_rst_n = 1'b1;
    tick();
    check("post_rst_issue_valid", 64'(out_issue_valid), 64'd0);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
